// File: rtl/expr_tx.sv
// ---------------------------------------------------------------------------
// expr_tx
// Serialises one arithmetic expression of single decimal digits joined by
// '+' or '*' as a stream of ASCII characters over a valid/ready handshake.
// A start request is checked for legality in IDLE. Legal operands and
// operators are latched, so later input changes cannot disturb a stream in
// flight. An illegal request is answered with a one-cycle err pulse.
//
// Ports
//   clk        in   single clock, rising edge
//   clr        in   synchronous active-low reset
//   start      in   request to send one expression (sampled in IDLE only)
//   num_terms  in   operand count, legal 1..MAX_TERMS
//   digits     in   operand k in bits [4k+3:4k], legal 0..9
//   ops        in   operator k joins operands k and k+1 (0 '+', 1 '*')
//   out_ready  in   receiver accepts the current character
//   out        out  ASCII character being sent
//   out_valid  out  out holds a valid character
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last character is accepted
//   err        out  one-cycle pulse after a rejected start request
// ---------------------------------------------------------------------------
module expr_tx #(
    parameter int MAX_TERMS = 4
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [2:0]             num_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic                   out_ready,
    output logic [7:0]             out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IDX_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_last;    // index of the final operand (n-1)
    logic [3:0]           r_digit [MAX_TERMS];
    logic [MAX_TERMS-2:0] r_ops;
    logic                 r_err;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_reject;

    // Only the operands actually in use are range-checked; the rest may
    // hold anything.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a
        // path that skips the assignment infers a latch.
        w_legal = (num_terms != 3'd0) && (int'(num_terms) <= MAX_TERMS);
        for (int k = 0; k < MAX_TERMS; k++) begin
            if ((k < int'(num_terms)) && (digits[4*k +: 4] > 4'd9)) begin
                w_legal = 1'b0;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && start && w_legal;
    assign w_reject = (r_state == IDLE) && start && !w_legal;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = DIGIT;
            DIGIT:   if (out_ready) w_next = (r_idx == r_last) ? DONE : OP;
            OP:      if (out_ready) w_next = DIGIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!clr) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_ops   <= '0;
            r_err   <= 1'b0;
            // NOTE: the operand store is explicitly cleared on reset so no
            // stale expression survives; a plain storage array would
            // normally be left unreset.
            for (int k = 0; k < MAX_TERMS; k++) begin
                r_digit[k] <= 4'd0;
            end
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_idx  <= '0;
                r_last <= IDX_W'(num_terms - 3'd1);
                r_ops  <= ops;
                for (int k = 0; k < MAX_TERMS; k++) begin
                    r_digit[k] <= digits[4*k +: 4];
                end
            end else if ((r_state == OP) && out_ready) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Outputs are decoded from state only. They are also forced low while
    // clr is held, so the reset cycle itself shows a quiet interface.
    always_comb begin
        out       = 8'h00;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            DIGIT: begin
                out       = 8'h30 + {4'h0, r_digit[r_idx]};
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            OP: begin
                out       = r_ops[r_idx] ? 8'h2A : 8'h2B;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
        if (!clr) begin
            out       = 8'h00;
            out_valid = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    assign err = r_err & clr;

endmodule

// File: tb/tb_expr_tx.sv
// ---------------------------------------------------------------------------
// tb_expr_tx
// Self-checking bench for expr_tx (MAX_TERMS = 4). A table of directed
// vectors is followed by hand-written handshake/reset sequences and a random
// phase. Expected character streams come from a transaction-level model:
// the expected text is built from the operands and operators, then consumed
// one character per accepted handshake.
// ---------------------------------------------------------------------------
module tb_expr_tx;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  num_terms;
    logic [15:0] digits;
    logic [2:0]  ops;
    logic        out_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    expr_tx #(.MAX_TERMS(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .num_terms (num_terms),
        .digits    (digits),
        .ops       (ops),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  n;
        logic [15:0] d;
        logic [2:0]  o;
        bit          exp_err;
        string       text;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_legal(input logic [2:0] n, input logic [15:0] d);
        if (n == 3'd0 || n > 3'd4) return 1'b0;
        for (int k = 0; k < int'(n); k++)
            if (d[4*k +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string model_text(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o);
        string s = "";
        for (int k = 0; k < int'(n); k++) begin
            s = {s, $sformatf("%c", 8'h30 + 8'(d[4*k +: 4]))};
            if (k < int'(n) - 1) s = {s, $sformatf("%c", o[k] ? 8'h2A : 8'h2B)};
        end
        return s;
    endfunction

    // Sends one legal expression and checks it character by character.
    // mode 0: ready always high (also checks done latency = 2n)
    // mode 1: random ready
    // mode 2: ready low for 3 cycles during the first operator
    // mode 3: ready high, start held high throughout the flight
    // During the flight the inputs are scrambled and start is toggled; none
    // of that may affect the stream or raise err.
    task automatic send(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o,
                        input int mode, input string exp_text);
        byte   q[$];
        string got = "";
        int    cyc;
        int    sent = 0;
        int    stall = 0;
        for (int i = 0; i < exp_text.len(); i++) q.push_back(exp_text[i]);
        num_terms = n; digits = d; ops = o; start = 1'b1; out_ready = 1'b1;
        step();
        cyc = 1;
        while (q.size() > 0 && cyc < 200) begin
            num_terms = 3'($urandom);
            digits    = 16'($urandom);
            ops       = 3'($urandom);
            start     = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            case (mode)
                1:       out_ready = (cyc > 60) ? 1'b1 : 1'($urandom_range(0, 1));
                2:       out_ready = !(sent == 1 && stall < 3);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && !out_ready) stall++;
            check("char_valid", 32'(out_valid), 32'd1);
            check("char_value", 32'(out), 32'(q[0]));
            check("char_busy", 32'(busy), 32'd1);
            check("char_done", 32'(done), 32'd0);
            check("char_err", 32'(err), 32'd0);
            if (out_ready) begin
                got = {got, $sformatf("%c", out)};
                void'(q.pop_front());
                sent++;
            end
            step();
            cyc++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout: %0d characters still pending", q.size());
        end
        start = 1'($urandom_range(0, 1));
        out_ready = 1'b1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_out", 32'(out), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        if (mode == 0) check("done_latency", 32'(cyc), 32'(2 * int'(n)));
        step();
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check_str("stream_text", got, exp_text);
    endtask

    task automatic reject(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o);
        num_terms = n; digits = d; ops = o; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        check("rej_err", 32'(err), 32'd1);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_valid", 32'(out_valid), 32'd0);
        step();
        check("rej_err_clear", 32'(err), 32'd0);
        check("rej_busy2", 32'(busy), 32'd0);
        check("rej_valid2", 32'(out_valid), 32'd0);
    endtask

    task automatic add_vec(input logic [2:0] n, input logic [15:0] d, input logic [2:0] o,
                           input bit e, input string t);
        vec_t v;
        v.n = n; v.d = d; v.o = o; v.exp_err = e; v.text = t;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0]  rn;
        logic [15:0] rd;
        logic [2:0]  ro;

        // Directed table: operand k lives in digits[4k+3:4k].
        add_vec(3'd3, 16'h0931, 3'b010, 1'b0, "1+3*9");
        add_vec(3'd1, 16'h0007, 3'b000, 1'b0, "7");
        add_vec(3'd4, 16'h2590, 3'b111, 1'b0, "0*9*5*2");
        add_vec(3'd2, 16'hFF84, 3'b000, 1'b0, "4+8");     // unused operands illegal
        add_vec(3'd3, 16'hA456, 3'b001, 1'b0, "6*5+4");
        add_vec(3'd0, 16'h0000, 3'b000, 1'b1, "");
        add_vec(3'd2, 16'h00A3, 3'b000, 1'b1, "");
        add_vec(3'd5, 16'h1111, 3'b000, 1'b1, "");
        add_vec(3'd4, 16'hF123, 3'b000, 1'b1, "");

        // Reset with a legal start pending: reset wins, interface stays quiet.
        clr = 1'b0; start = 1'b1; num_terms = 3'd2; digits = 16'h0012;
        ops = 3'b000; out_ready = 1'b1;
        repeat (3) step();
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        start = 1'b0;
        clr = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].exp_err) reject(vecs[i].n, vecs[i].d, vecs[i].o);
            else                 send(vecs[i].n, vecs[i].d, vecs[i].o, 0, vecs[i].text);
        end

        // Back-pressure during the first operator.
        send(3'd3, 16'h0931, 3'b010, 2, "1+3*9");

        // start held high throughout with other inputs, then an immediate
        // restart in the first IDLE cycle.
        send(3'd3, 16'h0931, 3'b010, 3, "1+3*9");
        send(3'd2, 16'h0085, 3'b001, 0, "5*8");

        // Reset while the second character is on the interface.
        num_terms = 3'd3; digits = 16'h0931; ops = 3'b010; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        check("abort_first", 32'(out), 32'h31);
        step();
        check("abort_second", 32'(out), 32'h2B);
        clr = 1'b0;
        #1;
        check("abort_valid_during", 32'(out_valid), 32'd0);
        step();
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        send(3'd2, 16'h0066, 3'b000, 0, "6+6");

        // Random expressions with random back-pressure.
        for (int it = 0; it < 40; it++) begin
            rn = 3'($urandom_range(1, 4));
            rd = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if (k < int'(rn)) rd[4*k +: 4] = 4'($urandom_range(0, 9));
            ro = 3'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) rn = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd6;
                else rd[0 +: 4] = 4'($urandom_range(10, 15));
            end
            if (model_legal(rn, rd)) send(rn, rd, ro, 1, model_text(rn, rd, ro));
            else                     reject(rn, rd, ro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 4, giving the maximum number of operands in one expression.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to send one expression; sampled only in IDLE.
REQ-005 The block SHALL have port num_terms, input, 3 bits: operand count, legal range 1..MAX_TERMS.
REQ-006 The block SHALL have port digits, input, 4*MAX_TERMS bits: operand k in bits [4k+3:4k], each legal 0..9.
REQ-007 The block SHALL have port ops, input, MAX_TERMS-1 bits: operator k joins operand k and k+1; 0 = '+' (8'h2B), 1 = '*' (8'h2A).
REQ-008 The block SHALL have port out_ready, input, 1 bit: receiver accepts the current character.
REQ-009 The block SHALL have port out, output, 8 bits: ASCII character being sent.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out holds a valid character.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last character is accepted.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse when a start request is rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, DIGIT, OP and DONE.
REQ-015 In IDLE, when start=1 and the inputs are legal, the block SHALL latch num_terms, digits and ops, set index=0 and go to DIGIT in the next cycle.
REQ-016 A start request SHALL be rejected when num_terms=0, num_terms>MAX_TERMS, or any of operands 0..num_terms-1 exceeds 9.
REQ-017 On a rejected start the block SHALL stay in IDLE and assert err for exactly one cycle.
REQ-018 Unused operands (index >= num_terms) SHALL NOT be checked for legality.
REQ-019 In DIGIT the block SHALL drive out = 8'h30 + latched operand[index] and out_valid=1.
REQ-020 In DIGIT, when out_ready=1 and index = n-1, the next state SHALL be DONE.
REQ-021 In DIGIT, when out_ready=1 and index < n-1, the next state SHALL be OP.
REQ-022 In OP the block SHALL drive out = the character for latched ops[index] and out_valid=1.
REQ-023 In OP, when out_ready=1, the block SHALL increment index and go to DIGIT.
REQ-024 In DIGIT and OP, while out_ready=0, state, index and out SHALL hold stable (no character dropped or repeated).
REQ-025 Each accepted character SHALL take exactly one cycle with out_valid=1 and out_ready=1.
REQ-026 An expression of n operands SHALL emit exactly 2n-1 characters, alternating digit and operator, starting and ending with a digit.
REQ-027 With out_ready held at 1, the first character SHALL appear one cycle after start is accepted and done SHALL follow 2n cycles after that acceptance.
REQ-028 In DONE the block SHALL assert done=1 with out_valid=0 for one cycle, then return to IDLE.
REQ-029 start asserted in DIGIT, OP or DONE SHALL be ignored, with no err pulse.
REQ-030 A new start SHALL be accepted in the first IDLE cycle after DONE.
REQ-031 Inputs changing after acceptance SHALL NOT affect the expression in flight.
REQ-032 In IDLE and DONE the block SHALL drive out=8'h00 and out_valid=0.
REQ-033 Every emitted stream SHALL be a valid expression under the team's expression recognizer grammar: single digits joined by '+' or '*'.

Reset
REQ-034 When clr=0 at a rising clk edge, the FSM SHALL go to IDLE and index and latched data SHALL clear to 0.
REQ-035 While clr=0, out SHALL be 8'h00 and out_valid, busy, done and err SHALL be 0.
REQ-036 Reset SHALL take priority over start, and over out_ready in any state.
REQ-037 Reset asserted mid-expression SHALL abort the expression with no done pulse.
REQ-038 The first start accepted after clr returns to 1 SHALL begin a fresh expression.

Verification
REQ-039 The bench SHALL check: num_terms=3, digits operands {1,3,9}, ops={1,0}, out_ready=1 -> out "1","+","3","*","9" on consecutive cycles, then done=1 one cycle.
REQ-040 The bench SHALL check: num_terms=1, operand0=7 -> a single "7", then done one cycle later, with busy high for 2 cycles.
REQ-041 The bench SHALL check: a 3-term expression with out_ready=0 for 3 cycles during the first OP -> out stays "+" and the sequence is otherwise identical.
REQ-042 The bench SHALL check: num_terms=0, and separately operand1=4'hA with num_terms=2 -> err pulses one cycle, busy stays 0, no characters.
REQ-043 The bench SHALL check: clr=0 while sending the second character -> next cycle out_valid=0, busy=0, and no done pulse.
REQ-044 The bench SHALL check: start pulsed in OP with different inputs -> ignored, the original expression completes, and a start in the following IDLE cycle is accepted.
